// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter constants: FSM encodings, register map offsets,
// status bit positions and a status-word packing helper for the load path.
package uart_tx_pkg;

  // State encodings, kept numerically stable for the memory controller and debug tools
  localparam logic [1:0] UART_STATE_IDLE  = 2'd0;
  localparam logic [1:0] UART_STATE_START = 2'd1;
  localparam logic [1:0] UART_STATE_DATA  = 2'd2;
  localparam logic [1:0] UART_STATE_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = UART_STATE_IDLE,
    ST_START = UART_STATE_START,
    ST_DATA  = UART_STATE_DATA,
    ST_STOP  = UART_STATE_STOP
  } uart_state_e;

  // Address offsets within the UART output-peripheral window
  localparam logic [7:0] UART_DATA_ADDR_OFFSET   = 8'h00;
  localparam logic [7:0] UART_STATUS_ADDR_OFFSET = 8'h04;

  // Status word bit positions
  localparam int UART_STAT_FULL_BIT     = 0;
  localparam int UART_STAT_EMPTY_BIT    = 1;
  localparam int UART_STAT_OVERFLOW_BIT = 2;
  localparam int UART_STAT_BUSY_BIT     = 3;

  localparam int UART_DATA_BITS = 8;

  // Assemble the status word returned to loads from the status address
  function automatic logic [3:0] uart_status_pack(input logic full,
                                                  input logic empty,
                                                  input logic overflow,
                                                  input logic busy);
    logic [3:0] s;
    s = '0;
    s[UART_STAT_FULL_BIT]     = full;
    s[UART_STAT_EMPTY_BIT]    = empty;
    s[UART_STAT_OVERFLOW_BIT] = overflow;
    s[UART_STAT_BUSY_BIT]     = busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// byte_fifo: circular byte buffer with wrapping pointers and a separate count.
// Push is accepted only when not full (full taken from the registered count);
// a push while full is dropped and reported on drop_o for that cycle, even if
// a pop happens in the same cycle. Pop is ignored when empty.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  import uart_tx_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == COUNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign drop_o  = push_i && full_o;

  // Next pointer and occupancy values from the accepted push/pop pair
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 serial transmitter. Stores to the data address
// arrive as write_enable_i pulses and queue bytes in byte_fifo; a bit-timing
// FSM drains the queue LSB first onto a registered tx line.
//
// Write interface: write_enable_i is a one-cycle push request with no ready
// return. A request is accepted on the edge where it is high and full_o is
// low; when full_o is high the byte is dropped and overflow_o becomes set
// (sticky until reset). Software is expected to poll full_o via the status
// address before storing.
module uart_tx #(
  parameter int CLOCKS_PER_BIT = 234,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          write_enable_i,
  input  logic [7:0]                    write_data_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output uart_tx_pkg::uart_state_e      state_o
);
  import uart_tx_pkg::*;

  localparam int BCW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CLOCKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [2:0]     IDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_drop;
  logic          bit_done;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (write_enable_i),
    .wdata_i (write_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop),
    .count_o (count_o)
  );

  assign bit_done = (bit_cnt_q == BIT_LAST);

  // Frame sequencing: bit timing, shift register, FIFO pop and next tx level
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx follows the state being entered so the line is driven from a flop
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Sticky overflow: any dropped write sets it until reset
  always_comb begin
    overflow_d = overflow_q | fifo_drop;
  end

  // FSM, datapath and line registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;
  assign overflow_o = overflow_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLOCKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          write_enable_i = 1'b0;
  logic [7:0]    write_data_i = 8'h00;
  logic          tx_o;
  logic          busy_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
  logic [CW-1:0] count_o;
  uart_state_e   state_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  uart_tx #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .write_enable_i (write_enable_i),
    .write_data_i   (write_data_i),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .overflow_o     (overflow_o),
    .count_o        (count_o),
    .state_o        (state_o)
  );

  // ---------------- scoreboard and line monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  logic       rx_stop_q[$];

  logic       mon_prev_tx  = 1'b0;
  logic       mon_in_frame = 1'b0;
  int         mon_k        = 0;
  int         mon_start    = 0;
  logic [7:0] mon_byte     = 8'h00;

  // Decode frames off the line by sampling mid-bit on the falling edge
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      mon_in_frame = 1'b0;
    end else if (!mon_in_frame) begin
      if (mon_prev_tx === 1'b1 && tx_o === 1'b0) begin
        mon_in_frame = 1'b1;
        mon_k        = 0;
        mon_start    = cyc;
      end
    end else begin
      mon_k++;
      if (mon_k >= CPB && mon_k < 9 * CPB && (mon_k % CPB) == CPB / 2)
        mon_byte[mon_k / CPB - 1] = tx_o;
      if (mon_k == 9 * CPB + CPB / 2) begin
        rx_q.push_back(mon_byte);
        rx_start_q.push_back(mon_start);
        rx_stop_q.push_back(tx_o);
        mon_in_frame = 1'b0;
      end
    end
    mon_prev_tx = tx_o;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    write_enable_i = 1'b0;
    tick(2);
    rst_i = 1'b0;
    exp_q.delete();
    rx_q.delete();
    rx_start_q.delete();
    rx_stop_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept);
    write_enable_i = 1'b1;
    write_data_i   = b;
    if (accept) exp_q.push_back(b);
    tick(1);
    write_enable_i = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int w;
    w = 0;
    while (rx_q.size() < n && w < budget) begin
      tick(1);
      w++;
    end
    ok = (rx_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full_o); end
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    checks++; if (count_o !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (state_o !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state_o, ST_IDLE); end
    for (int c = 0; c < 20; c++) begin
      tick(1);
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || empty_o !== 1'b1 || count_o !== '0) begin
        failures++;
        $display("FAIL idle_cycle_%0d: got tx=%b busy=%b empty=%b count=%0d expected tx=1 busy=0 empty=1 count=0",
                 c, tx_o, busy_o, empty_o, count_o);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    logic [7:0] exp_b;
    bit ok;
    frame = {1'b1, 8'hA5, 1'b0};
    do_reset();
    write_byte(8'hA5, 1'b1);
    checks++; if (count_o !== CW'(1)) begin failures++; $display("FAIL single_count_after_push: got %0d expected 1", count_o); end
    checks++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL single_line_after_push: got tx=%b busy=%b expected tx=1 busy=0", tx_o, busy_o); end
    tick(1);
    checks++; if (count_o !== '0) begin failures++; $display("FAIL single_count_after_pop: got %0d expected 0", count_o); end
    checks++; if (state_o !== ST_START) begin failures++; $display("FAIL single_state_after_pop: got %0d expected %0d", state_o, ST_START); end
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (tx_o !== frame[c / CPB] || busy_o !== 1'b1) begin
        failures++;
        $display("FAIL single_line_cycle_%0d: got tx=%b busy=%b expected tx=%b busy=1", c, tx_o, busy_o, frame[c / CPB]);
      end
      tick(1);
    end
    checks++; if (busy_o !== 1'b0 || tx_o !== 1'b1) begin failures++; $display("FAIL single_end: got busy=%b tx=%b expected busy=0 tx=1", busy_o, tx_o); end
    wait_rx(1, 20, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_rx_timeout: got %0d frames expected 1", rx_q.size());
    end else begin
      exp_b = exp_q.pop_front();
      if (rx_q[0] !== exp_b || rx_stop_q[0] !== 1'b1) begin
        failures++; $display("FAIL single_rx_byte: got %h stop=%b expected %h stop=1", rx_q[0], rx_stop_q[0], exp_b);
      end
    end
  endtask

  task automatic test_burst_overflow();
    logic [7:0] exp_b;
    bit ok;
    do_reset();
    for (int i = 0; i < 9; i++) write_byte(8'(i), 1'b1);
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL burst_no_overflow: got %b expected 0", overflow_o); end
    checks++; if (count_o !== CW'(8) || full_o !== 1'b1) begin failures++; $display("FAIL burst_count: got count=%0d full=%b expected count=8 full=1", count_o, full_o); end
    write_byte(8'h09, 1'b0);
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL burst_overflow: got %b expected 1", overflow_o); end
    checks++; if (count_o !== CW'(8)) begin failures++; $display("FAIL burst_count_after_drop: got %0d expected 8", count_o); end
    wait_rx(9, 9 * (FRAME + 1) + 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL burst_rx_timeout: got %0d frames expected 9", rx_q.size()); end
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_q[i] !== exp_b || rx_stop_q[i] !== 1'b1) begin
        failures++; $display("FAIL burst_rx_byte_%0d: got %h stop=%b expected %h stop=1", i, rx_q[i], rx_stop_q[i], exp_b);
      end
      if (i > 0) begin
        checks++;
        if (rx_start_q[i] - rx_start_q[i-1] !== FRAME + 1) begin
          failures++; $display("FAIL burst_spacing_%0d: got %0d expected %0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME + 1);
        end
      end
    end
    checks++; if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin failures++; $display("FAIL burst_drained: got empty=%b overflow=%b expected empty=1 overflow=1", empty_o, overflow_o); end
  endtask

  task automatic test_full_hold();
    logic [7:0] exp_b;
    bit ok;
    do_reset();
    write_byte(8'h3C, 1'b1);
    tick(2);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL full_frame_in_flight: got busy=%b expected 1", busy_o); end
    for (int i = 0; i < DEPTH; i++) write_byte(8'h40 + 8'(i), 1'b1);
    checks++; if (count_o !== CW'(DEPTH) || full_o !== 1'b1 || overflow_o !== 1'b0) begin
      failures++; $display("FAIL full_filled: got count=%0d full=%b overflow=%b expected count=8 full=1 overflow=0", count_o, full_o, overflow_o);
    end
    write_byte(8'hEE, 1'b0);
    checks++; if (count_o !== CW'(DEPTH) || full_o !== 1'b1 || overflow_o !== 1'b1) begin
      failures++; $display("FAIL full_drop: got count=%0d full=%b overflow=%b expected count=8 full=1 overflow=1", count_o, full_o, overflow_o);
    end
    wait_rx(9, 9 * (FRAME + 1) + 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_rx_timeout: got %0d frames expected 9", rx_q.size()); end
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_q[i] !== exp_b) begin failures++; $display("FAIL full_rx_byte_%0d: got %h expected %h", i, rx_q[i], exp_b); end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    write_byte(8'hFF, 1'b1);
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    // pop happened on the edge after the 0xFF push; bit 3 of DATA spans edges +17..+20 after it
    tick(16);
    checks++; if (state_o !== ST_DATA || tx_o !== 1'b1 || count_o !== CW'(2)) begin
      failures++; $display("FAIL midframe_pre: got state=%0d tx=%b count=%0d expected state=%0d tx=1 count=2", state_o, tx_o, count_o, ST_DATA);
    end
    rst_i = 1'b1;
    tick(1);
    checks++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL midframe_line: got tx=%b busy=%b expected tx=1 busy=0", tx_o, busy_o); end
    checks++; if (count_o !== '0 || empty_o !== 1'b1) begin failures++; $display("FAIL midframe_flush: got count=%0d empty=%b expected count=0 empty=1", count_o, empty_o); end
    rst_i = 1'b0;
    exp_q.delete();
    rx_q.delete();
    rx_start_q.delete();
    rx_stop_q.delete();
    for (int c = 0; c < 60; c++) begin
      tick(1);
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
        failures++; $display("FAIL midframe_quiet_%0d: got tx=%b busy=%b expected tx=1 busy=0", c, tx_o, busy_o);
      end
    end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL midframe_no_frames: got %0d frames expected 0", rx_q.size()); end
  endtask

  task automatic test_push_on_pop();
    logic [7:0] exp_b;
    int n0;
    bit ok;
    do_reset();
    write_byte(8'hA1, 1'b1);
    n0 = cyc;
    write_byte(8'hB2, 1'b1);
    write_byte(8'hC3, 1'b1);
    write_byte(8'hD4, 1'b1);
    while (cyc < n0 + FRAME + 1) tick(1);
    checks++; if (state_o !== ST_IDLE || count_o !== CW'(3)) begin
      failures++; $display("FAIL pop_pre: got state=%0d count=%0d expected state=%0d count=3", state_o, count_o, ST_IDLE);
    end
    write_byte(8'hE5, 1'b1);
    checks++; if (count_o !== CW'(3)) begin failures++; $display("FAIL pop_count: got %0d expected 3", count_o); end
    checks++; if (state_o !== ST_START || tx_o !== 1'b0) begin failures++; $display("FAIL pop_start: got state=%0d tx=%b expected state=%0d tx=0", state_o, tx_o, ST_START); end
    wait_rx(5, 5 * (FRAME + 1) + 50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pop_rx_timeout: got %0d frames expected 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (rx_q[i] !== exp_b) begin failures++; $display("FAIL pop_rx_byte_%0d: got %h expected %h", i, rx_q[i], exp_b); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_byte();
    test_burst_overflow();
    test_full_hold();
    test_reset_mid_frame();
    test_push_on_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
